// File: rtl/debug_reg_select_if.sv
// Register-select bundle: raw user inputs, register-file debug
// read port and the captured word handed to the display stage.
interface debug_reg_select_if #(
  parameter int IDX_W = 5
);
  logic             btn_next;
  logic             btn_prev;
  logic             freeze;
  logic [31:0]      dbg_rdata;
  logic [IDX_W-1:0] dbg_raddr;
  logic [IDX_W-1:0] sel_idx;
  logic [31:0]      register;

  modport master (
    input  btn_next,
    input  btn_prev,
    input  freeze,
    input  dbg_rdata,
    output dbg_raddr,
    output sel_idx,
    output register
  );

  modport slave (
    output btn_next,
    output btn_prev,
    output freeze,
    output dbg_rdata,
    input  dbg_raddr,
    input  sel_idx,
    input  register
  );
endinterface

// File: rtl/debug_reg_select.sv
// Steps a register index with debounced next/prev buttons and
// captures the register-file debug read into a stable display word.
module debug_reg_select #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REG_COUNT       = 32,
  parameter int IDX_W           = 5
) (
  input logic              clk,
  input logic              rst,
  debug_reg_select_if.master bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_MAX =
    IDX_W'(REG_COUNT - 1);

  // bit 0 = next, bit 1 = prev, bit 2 = freeze
  logic [2:0] s1;
  logic [2:0] s2;

  logic [1:0][CNT_W-1:0] cnt;
  logic [1:0]            deb;
  logic [1:0]            deb_q;
  logic [1:0]            rise;
  logic                  inc_p;
  logic                  dec_p;

  logic [IDX_W-1:0] sel;
  logic             load_req;
  logic [31:0]      reg_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= {bus.freeze, bus.btn_prev, bus.btn_next};
      s2 <= s1;
    end
  end

  // Any return to the accepted level restarts the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      deb <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          deb[i] <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign rise  = deb & ~deb_q;
  assign inc_p = rise[0];
  assign dec_p = rise[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_q    <= '0;
      sel      <= '0;
      load_req <= 1'b0;
    end else begin
      deb_q    <= deb;
      load_req <= 1'b0;
      unique case (1'b1)
        (inc_p && !dec_p): begin
          sel      <= (sel == IDX_MAX) ? '0 : sel + 1'b1;
          load_req <= 1'b1;
        end
        (dec_p && !inc_p): begin
          sel      <= (sel == '0) ? IDX_MAX : sel - 1'b1;
          load_req <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // load_req lines up with read data for the new address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_q <= '0;
    end else if (!s2[2] || load_req) begin
      reg_q <= bus.dbg_rdata;
    end
  end

  assign bus.sel_idx   = sel;
  assign bus.dbg_raddr = sel;
  assign bus.register  = reg_q;

endmodule

// File: tb/tb_debug_reg_select.sv
// Directed bench for debug_reg_select with a register-file model
// and an expected-value queue drained at each sample point.
module tb_debug_reg_select;

  logic clk;
  logic rst;

  debug_reg_select_if #(.IDX_W(5)) bus ();

  debug_reg_select #(
    .DEBOUNCE_CYCLES(4),
    .REG_COUNT(32),
    .IDX_W(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [31:0] mem [32];
  assign bus.dbg_rdata = mem[bus.dbg_raddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int lr_cnt = 0;
  always @(posedge clk) if (dut.load_req) lr_cnt++;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_out(input logic [4:0] idx,
                            input logic [31:0] val);
    exp_t e;
    e.idx = idx;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $error("FAIL %s scoreboard empty", tag);
      return;
    end
    e = exp_q.pop_front();
    n_checks++;
    assert (bus.sel_idx === e.idx) n_pass++;
    else $error("FAIL %s sel_idx got %0d want %0d",
                tag, bus.sel_idx, e.idx);
    n_checks++;
    assert (bus.dbg_raddr === e.idx) n_pass++;
    else $error("FAIL %s dbg_raddr got %0d want %0d",
                tag, bus.dbg_raddr, e.idx);
    n_checks++;
    assert (bus.register === e.val) n_pass++;
    else $error("FAIL %s register got %h want %h",
                tag, bus.register, e.val);
  endtask

  task automatic press(input logic nxt, input logic prv,
                       input int n);
    bus.btn_next = nxt;
    bus.btn_prev = prv;
    tick(n);
    bus.btn_next = 1'b0;
    bus.btn_prev = 1'b0;
    tick(10);
  endtask

  initial begin
    int lr0;
    for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + i;
    rst          = 1'b1;
    bus.btn_next = 1'b0;
    bus.btn_prev = 1'b0;
    bus.freeze   = 1'b0;

    tick(2);
    expect_out(5'd0, 32'h0);
    chk("reset");
    rst = 1'b0;
    tick(2);
    expect_out(5'd0, 32'hA000_0000);
    chk("post_reset");

    press(1'b1, 1'b0, 3);
    expect_out(5'd0, 32'hA000_0000);
    chk("glitch");

    bus.btn_next = 1'b1;
    tick(7);
    expect_out(5'd1, 32'hA000_0000);
    chk("lag_pre");
    tick(1);
    expect_out(5'd1, 32'hA000_0001);
    chk("lag_post");
    bus.btn_next = 1'b0;
    tick(10);
    expect_out(5'd1, 32'hA000_0001);
    chk("once");

    for (int i = 0; i < 30; i++) press(1'b1, 1'b0, 5);
    expect_out(5'd31, 32'hA000_001F);
    chk("step_31");
    press(1'b1, 1'b0, 5);
    expect_out(5'd0, 32'hA000_0000);
    chk("wrap_next");
    press(1'b0, 1'b1, 5);
    expect_out(5'd31, 32'hA000_001F);
    chk("wrap_prev");

    lr0 = lr_cnt;
    press(1'b1, 1'b1, 8);
    expect_out(5'd31, 32'hA000_001F);
    chk("both");
    n_checks++;
    assert (lr_cnt - lr0 === 0) n_pass++;
    else $error("FAIL both_load_req got %0d pulses want 0",
                lr_cnt - lr0);

    for (int i = 0; i < 4; i++) press(1'b1, 1'b0, 5);
    expect_out(5'd3, 32'hA000_0003);
    chk("at_3");

    bus.freeze = 1'b1;
    tick(4);
    mem[3] = 32'hDEAD_BEEF;
    tick(3);
    expect_out(5'd3, 32'hA000_0003);
    chk("frozen");
    press(1'b1, 1'b0, 5);
    expect_out(5'd4, 32'hA000_0004);
    chk("frozen_reload");
    mem[4] = 32'h55AA_55AA;
    tick(3);
    expect_out(5'd4, 32'hA000_0004);
    chk("frozen_hold");
    bus.freeze = 1'b0;
    tick(4);
    mem[4] = 32'h1234_5678;
    tick(1);
    expect_out(5'd4, 32'h1234_5678);
    chk("unfrozen");

    bus.btn_next = 1'b1;
    tick(2);
    #2 rst = 1'b1;
    #1;
    expect_out(5'd0, 32'h0);
    chk("async_reset");
    bus.btn_next = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(3);
    expect_out(5'd0, 32'hA000_0000);
    chk("reset_release");
    press(1'b1, 1'b0, 3);
    expect_out(5'd0, 32'hA000_0000);
    chk("short_after_reset");
    press(1'b1, 1'b0, 4);
    expect_out(5'd1, 32'hA000_0001);
    chk("full_after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
